// File: rtl/c_selector_pkg.sv
// Shared helpers for the c_selector_n router: pointer sizing, mask decode and
// saturating arithmetic.
package c_selector_pkg;

    localparam int MAX_OUT = 16;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Isolate the lowest set bit (two's-complement trick); zero stays zero.
    function automatic logic [MAX_OUT-1:0] lowest_set(input logic [MAX_OUT-1:0] m);
        return m & (~m + MAX_OUT'(1));
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v >= max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/c_selector_fifo.sv
// Single-clock per-channel FIFO; head reads zero while empty.
module c_selector_fifo
    import c_selector_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    // Extra MSB on each pointer tells a full ring from an empty one.
    logic [PTR_W:0]        wr_ptr, rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head  = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[PTR_W-1:0]] <= din;
                wr_ptr                 <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop && !empty) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/c_selector_n.sv
// Mask-routed 1-to-NUM_OUT selector with a FIFO per output channel and a
// saturating counter of words dropped for an empty effective mask.
module c_selector_n
    import c_selector_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_OUT      = 4,
    parameter int DEPTH        = 2,
    parameter int MULTICAST_EN = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [DATA_WIDTH+NUM_OUT-1:0]   i_data,
    output logic [NUM_OUT-1:0]              o_valid,
    input  logic [NUM_OUT-1:0]              i_ready,
    output logic [NUM_OUT*DATA_WIDTH-1:0]   o_data,
    output logic [CNT_WIDTH-1:0]            o_drop_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [NUM_OUT-1:0]    mask, em, full, empty, push, pop;
    logic [DATA_WIDTH-1:0] payload;
    logic                  rdy_en, accept;

    assign mask    = i_data[DATA_WIDTH +: NUM_OUT];
    assign payload = i_data[DATA_WIDTH-1:0];
    assign em      = (MULTICAST_EN != 0) ? mask
                                         : NUM_OUT'(lowest_set(MAX_OUT'(mask)));

    // Any full channel blocks every word, which keeps multicast writes atomic.
    assign o_ready = rdy_en & ~|full;
    assign accept  = i_valid & o_ready;
    assign push    = {NUM_OUT{accept}} & em;
    assign pop     = ~empty & i_ready;
    assign o_valid = ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_en     <= 1'b0;
            o_drop_cnt <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (accept && (em == '0))
                o_drop_cnt <= CNT_WIDTH'(sat_inc(32'(o_drop_cnt), 32'(CNT_MAX)));
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_ch
        c_selector_fifo #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH)
        ) u_fifo (
            .clk  (clk),
            .rst  (rst),
            .push (push[k]),
            .pop  (pop[k]),
            .din  (payload),
            .full (full[k]),
            .empty(empty[k]),
            .head (o_data[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule
